// File: rtl/fxp8s_mat_stream_tx.sv
// Transmit side of the fxp8s matrix stream: buffers operand matrices A and B with
// ragged row lengths / row counts and sends them row-major with padding markers.
module fxp8s_mat_stream_tx #(
    parameter int DIM   = 2,
    parameter int WIDTH = 8,
    parameter int AW    = (DIM > 2) ? $clog2(DIM) : 1,
    parameter int LW    = $clog2(DIM + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_en,
    input  logic             ld_mat,
    input  logic [AW-1:0]    ld_row,
    input  logic [AW-1:0]    ld_col,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             len_we,
    input  logic             rows_we,
    input  logic [LW-1:0]    cnt_val,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             tx_en,
    input  logic             tx_rdy,
    output logic             tx_mat,
    output logic             tx_new_row,
    output logic             tx_mat_done,
    output logic [WIDTH-1:0] tx_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEND   = 3'd1;
    localparam logic [2:0] S_ROWPAD = 3'd2;
    localparam logic [2:0] S_MATPAD = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;
    localparam logic [LW-1:0] DIM_L = LW'(DIM);

    logic [WIDTH-1:0] mem_q  [2][DIM][DIM];
    logic [WIDTH-1:0] mem_d  [2][DIM][DIM];
    logic [LW-1:0]    len_q  [2][DIM];
    logic [LW-1:0]    len_d  [2][DIM];
    logic [LW-1:0]    rows_q [2];
    logic [LW-1:0]    rows_d [2];

    logic [2:0]       st_q, st_d;
    logic             m_q, m_d;
    logic [AW-1:0]    r_q, r_d, c_q, c_d;

    logic             tx_en_q, tx_en_d, tx_mat_q, tx_mat_d;
    logic             tx_nr_q, tx_nr_d, tx_md_q, tx_md_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             done_q, done_d;

    logic             idle, row_ok, col_ok;
    logic [LW-1:0]    cnt_c;

    // Loads commit through *_d so a load coincident with start is seen by the first beat.
    always_comb begin
        idle   = (st_q == S_IDLE);
        row_ok = 32'(ld_row) < DIM;
        col_ok = 32'(ld_col) < DIM;
        cnt_c  = (cnt_val > DIM_L) ? DIM_L : cnt_val;
        mem_d  = mem_q;
        len_d  = len_q;
        rows_d = rows_q;
        if (idle && ld_en && row_ok && col_ok) mem_d[ld_mat][ld_row][ld_col] = ld_data;
        if (idle && len_we && row_ok)          len_d[ld_mat][ld_row] = cnt_c;
        if (idle && rows_we)                   rows_d[ld_mat] = cnt_c;
    end

    logic          adv, do_rs, do_re, do_me, do_ms, ms_m;
    logic [AW-1:0] rs_r;

    // Beat sequencer: row end -> matrix end -> matrix start -> row start, each may chain into the next.
    always_comb begin
        st_d  = st_q;
        m_d   = m_q;
        r_d   = r_q;
        c_d   = c_q;
        adv   = tx_en_q & tx_rdy;
        do_rs = 1'b0;
        do_re = 1'b0;
        do_me = 1'b0;
        do_ms = 1'b0;
        ms_m  = 1'b0;
        rs_r  = '0;
        case (st_q)
            S_IDLE:   if (start) do_ms = 1'b1;
            S_SEND:   if (adv) begin
                if (LW'(c_q) + LW'(1) < len_d[m_q][r_q]) c_d = c_q + AW'(1);
                else do_re = 1'b1;
            end
            S_ROWPAD: if (adv) begin
                do_rs = 1'b1;
                rs_r  = r_q + AW'(1);
            end
            S_MATPAD: if (adv) do_me = 1'b1;
            default:  st_d = S_IDLE;
        endcase
        if (do_re) begin
            if (LW'(r_q) + LW'(1) == rows_d[m_q]) begin
                if (rows_d[m_q] == DIM_L && len_d[m_q][r_q] == DIM_L) do_me = 1'b1;
                else st_d = S_MATPAD;
            end else if (len_d[m_q][r_q] != DIM_L) begin
                st_d = S_ROWPAD;
            end else begin
                do_rs = 1'b1;
                rs_r  = r_q + AW'(1);
            end
        end
        if (do_me) begin
            if (!m_q) begin
                do_ms = 1'b1;
                ms_m  = 1'b1;
            end else begin
                st_d = S_FIN;
            end
        end
        if (do_ms) begin
            m_d = ms_m;
            if (rows_d[ms_m] == '0) st_d = S_MATPAD;
            else begin
                do_rs = 1'b1;
                rs_r  = '0;
            end
        end
        if (do_rs) begin
            r_d = rs_r;
            c_d = '0;
            if (len_d[m_d][rs_r] != '0)                    st_d = S_SEND;
            else if (LW'(rs_r) + LW'(1) == rows_d[m_d])    st_d = S_MATPAD;
            else                                           st_d = S_ROWPAD;
        end
    end

    always_comb begin
        tx_en_d   = (st_d == S_SEND) || (st_d == S_ROWPAD) || (st_d == S_MATPAD);
        tx_mat_d  = tx_en_d & m_d;
        tx_nr_d   = (st_d == S_ROWPAD);
        tx_md_d   = (st_d == S_MATPAD);
        tx_data_d = (st_d == S_SEND) ? mem_d[m_d][r_d][c_d] : '0;
        done_d    = (st_d == S_FIN) && (st_q != S_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                rows_q[m] <= DIM_L;
                for (int r = 0; r < DIM; r++) begin
                    len_q[m][r] <= DIM_L;
                    for (int c = 0; c < DIM; c++) mem_q[m][r][c] <= '0;
                end
            end
            st_q      <= S_IDLE;
            m_q       <= 1'b0;
            r_q       <= '0;
            c_q       <= '0;
            tx_en_q   <= 1'b0;
            tx_mat_q  <= 1'b0;
            tx_nr_q   <= 1'b0;
            tx_md_q   <= 1'b0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            len_q     <= len_d;
            rows_q    <= rows_d;
            st_q      <= st_d;
            m_q       <= m_d;
            r_q       <= r_d;
            c_q       <= c_d;
            tx_en_q   <= tx_en_d;
            tx_mat_q  <= tx_mat_d;
            tx_nr_q   <= tx_nr_d;
            tx_md_q   <= tx_md_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
        end
    end

    // busy spans exactly the cycles a beat is being offered
    assign busy        = tx_en_q;
    assign done        = done_q;
    assign tx_en       = tx_en_q;
    assign tx_mat      = tx_mat_q;
    assign tx_new_row  = tx_nr_q;
    assign tx_mat_done = tx_md_q;
    assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_fxp8s_mat_stream_tx.sv
// Bench for fxp8s_mat_stream_tx: beats are checked against a queue built from the
// ragged-shape framing rules, under directed and randomized ready / shape patterns.
module tb_fxp8s_mat_stream_tx;
    localparam int DIM   = 2;
    localparam int WIDTH = 8;
    localparam int AW    = 1;
    localparam int LW    = 2;

    logic             clk = 1'b0;
    logic             rst, ld_en, ld_mat, len_we, rows_we, start, tx_rdy;
    logic [AW-1:0]    ld_row, ld_col;
    logic [WIDTH-1:0] ld_data;
    logic [LW-1:0]    cnt_val;
    logic             busy, done, tx_en, tx_mat, tx_new_row, tx_mat_done;
    logic [WIDTH-1:0] tx_data;

    always #5 clk = ~clk;

    fxp8s_mat_stream_tx #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_mat(ld_mat), .ld_row(ld_row),
        .ld_col(ld_col), .ld_data(ld_data), .len_we(len_we), .rows_we(rows_we),
        .cnt_val(cnt_val), .start(start), .busy(busy), .done(done), .tx_en(tx_en),
        .tx_rdy(tx_rdy), .tx_mat(tx_mat), .tx_new_row(tx_new_row),
        .tx_mat_done(tx_mat_done), .tx_data(tx_data)
    );

    int checks = 0;
    int failures = 0;
    int mdl_mem [2][DIM][DIM];
    int mdl_len [2][DIM];
    int mdl_rows [2];
    logic [WIDTH+2:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int m = 0; m < 2; m++) begin
            mdl_rows[m] = DIM;
            for (int r = 0; r < DIM; r++) begin
                mdl_len[m][r] = DIM;
                for (int c = 0; c < DIM; c++) mdl_mem[m][r][c] = 0;
            end
        end
    endtask

    // Beat word = {mat, new_row, mat_done, data}
    task automatic build_expected();
        logic mb;
        exp_q.delete();
        for (int m = 0; m < 2; m++) begin
            mb = (m == 1);
            for (int r = 0; r < mdl_rows[m]; r++) begin
                for (int c = 0; c < mdl_len[m][r]; c++)
                    exp_q.push_back({mb, 2'b00, WIDTH'(mdl_mem[m][r][c])});
                if (r < mdl_rows[m] - 1 && mdl_len[m][r] < DIM)
                    exp_q.push_back({mb, 2'b10, {WIDTH{1'b0}}});
            end
            if (!(mdl_rows[m] == DIM && mdl_len[m][DIM-1] == DIM))
                exp_q.push_back({mb, 2'b01, {WIDTH{1'b0}}});
        end
    endtask

    // kind: 0 element, 1 row length, 2 row count
    task automatic do_load(input int kind, input int m, input int r, input int c, input int v);
        @(negedge clk);
        ld_mat  = (m == 1);
        ld_row  = AW'(r);
        ld_col  = AW'(c);
        ld_data = WIDTH'(v);
        cnt_val = LW'(v);
        ld_en   = (kind == 0);
        len_we  = (kind == 1);
        rows_we = (kind == 2);
        @(negedge clk);
        ld_en = 1'b0; len_we = 1'b0; rows_we = 1'b0;
        if (kind == 0)      mdl_mem[m][r][c] = v & 255;
        else if (kind == 1) mdl_len[m][r] = (v > DIM) ? DIM : v;
        else                mdl_rows[m] = (v > DIM) ? DIM : v;
    endtask

    // mode: 0 ready always, 1 random ready, 2 stall each marker two cycles
    task automatic run_transfer(input string tag, input int mode, input bit poke,
                                input bit co_ld, input int co_v);
        int idx = 0, cyc = 0, stalls = 0, nexp;
        bit held = 1'b0, fin = 1'b0;
        logic [WIDTH+2:0] cur, prev = '0;
        if (co_ld) mdl_mem[0][0][0] = co_v & 255;
        build_expected();
        nexp = exp_q.size();
        @(negedge clk);
        start = 1'b1;
        if (co_ld) begin
            ld_en = 1'b1; ld_mat = 1'b0; ld_row = '0; ld_col = '0; ld_data = WIDTH'(co_v);
        end
        @(negedge clk);
        while (!fin && cyc < 200) begin
            cyc++;
            start = 1'b0; ld_en = 1'b0; len_we = 1'b0; rows_we = 1'b0;
            cur = {tx_mat, tx_new_row, tx_mat_done, tx_data};
            if (held) begin
                chk({tag, "_hold_en"}, tx_en, 1);
                chk({tag, "_hold_beat"}, cur, prev);
            end
            if (idx < nexp) begin
                chk({tag, "_en"}, tx_en, 1);
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_both_markers"}, tx_new_row & tx_mat_done, 0);
                if (mode == 1)                                        tx_rdy = 1'($urandom_range(0, 1));
                else if (mode == 2 && (tx_new_row | tx_mat_done) && stalls < 2) tx_rdy = 1'b0;
                else                                                  tx_rdy = 1'b1;
                if (tx_rdy) begin
                    chk($sformatf("%s_beat%0d", tag, idx), cur, exp_q[idx]);
                    idx++;
                    stalls = 0;
                end else begin
                    stalls++;
                end
                held = !tx_rdy;
                prev = cur;
                if (poke && cyc == 2) begin
                    ld_en = 1'b1; len_we = 1'b1; rows_we = 1'b1; start = 1'b1;
                    ld_mat = 1'b0; ld_row = '0; ld_col = '0; ld_data = 8'hEE; cnt_val = '0;
                end
                @(negedge clk);
            end else begin
                tx_rdy = 1'b0;
                chk({tag, "_done"}, done, 1);
                chk({tag, "_done_en"}, tx_en, 0);
                chk({tag, "_done_busy"}, busy, 0);
                if (mode == 0) chk({tag, "_latency"}, cyc, nexp + 1);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk({tag, "_post_done"}, done, 0);
                chk({tag, "_post_en"}, tx_en, 0);
                chk({tag, "_post_busy"}, busy, 0);
                fin = 1'b1;
            end
        end
        if (!fin) chk({tag, "_timeout"}, 0, 1);
        tx_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld_en = 1'b0; ld_mat = 1'b0; len_we = 1'b0; rows_we = 1'b0;
        start = 1'b0; tx_rdy = 1'b0; ld_row = '0; ld_col = '0; ld_data = '0; cnt_val = '0;
        mdl_reset();
        repeat (2) @(negedge clk);
        chk("rst_outs", {busy, done, tx_en, tx_mat, tx_new_row, tx_mat_done, tx_data}, 0);
        rst = 1'b0;

        for (int m = 0; m < 2; m++)
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) do_load(0, m, r, c, m * 4 + r * 2 + c + 1);
        run_transfer("full", 0, 1'b0, 1'b0, 0);

        do_load(1, 0, 0, 0, 1);
        run_transfer("rowpad_stall", 2, 1'b0, 1'b0, 0);
        do_load(1, 0, 0, 0, 2);

        do_load(2, 1, 0, 0, 1);
        run_transfer("b_rows1", 0, 1'b0, 1'b0, 0);
        do_load(2, 1, 0, 0, 0);
        run_transfer("b_rows0", 0, 1'b0, 1'b0, 0);
        do_load(2, 1, 0, 0, 2);
        do_load(1, 0, 1, 0, 0);
        run_transfer("a_len0_last", 0, 1'b0, 1'b0, 0);
        do_load(1, 0, 1, 0, 2);

        run_transfer("rand_rdy0", 1, 1'b0, 1'b0, 0);
        run_transfer("rand_rdy1", 1, 1'b0, 1'b0, 0);

        run_transfer("busy_poke", 0, 1'b1, 1'b0, 0);
        run_transfer("after_poke", 0, 1'b0, 1'b0, 0);
        run_transfer("load_with_start", 0, 1'b0, 1'b1, 9);
        do_load(1, 1, 0, 0, 1);
        do_load(1, 1, 0, 0, 3);
        do_load(2, 0, 0, 0, 3);
        run_transfer("clamp", 0, 1'b0, 1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            for (int m = 0; m < 2; m++) begin
                do_load(2, m, 0, 0, int'($urandom_range(0, 3)));
                for (int r = 0; r < DIM; r++) begin
                    do_load(1, m, r, 0, int'($urandom_range(0, 3)));
                    for (int c = 0; c < DIM; c++) do_load(0, m, r, c, int'($urandom_range(0, 255)));
                end
            end
            run_transfer($sformatf("rand%0d", t), 1, 1'b0, 1'b0, 0);
        end

        // Abort mid-stream after three accepted beats
        @(negedge clk);
        start = 1'b1;
        tx_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tx_rdy = 1'b0;
        @(negedge clk);
        chk("abort_en", tx_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        mdl_reset();
        run_transfer("restart_zero", 0, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
